// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the stack-pointer sequencer and the control unit decoder.
package stack_seq_pkg;

    localparam int unsigned SP_W   = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [1:0] {
        PUSH = 2'b00,
        POP  = 2'b01,
        LOAD = 2'b10,
        PEEK = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [REG_W-1:0] REG_NONE  = 4'h0;
    localparam logic [REG_W-1:0] REG_SP_LO = 4'hE;
    localparam logic [REG_W-1:0] REG_SP_HI = 4'hF;

    // Request payload captured at acceptance
    typedef struct packed {
        op_t             op;
        logic [SP_W-1:0] data;
    } req_t;

    // PUSH pre-decrements, everything else that moves SP increments
    function automatic logic [SP_W-1:0] sp_step(input op_t op, input logic [SP_W-1:0] sp);
        return (op == PUSH) ? sp - SP_W'(1) : sp + SP_W'(1);
    endfunction

    // True when the low-half update ripples into the high half
    function automatic logic carry_out(input op_t op, input logic [HALF_W-1:0] lo);
        case (op)
            PUSH:    return lo == HALF_W'(0);
            POP:     return lo == {HALF_W{1'b1}};
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Request handshake plus register-file read-A/write bus between control unit, sequencer and RF.
interface stack_seq_if;

    logic                                      req_valid;
    stack_seq_pkg::op_t                        req_op;
    logic [stack_seq_pkg::SP_W-1:0]            req_data;
    logic                                      req_ready;
    logic                                      done;
    logic [stack_seq_pkg::SP_W-1:0]            addr;
    logic [stack_seq_pkg::REG_W-1:0]           rf_src_a;
    logic                                      rf_src_a_en;
    logic [stack_seq_pkg::HALF_W-1:0]          rf_a;
    logic                                      rf_we;
    logic [stack_seq_pkg::REG_W-1:0]           rf_src_w;
    logic [stack_seq_pkg::HALF_W-1:0]          rf_val;

    modport master (
        output req_valid, req_op, req_data, rf_a,
        input  req_ready, done, addr, rf_src_a, rf_src_a_en, rf_we, rf_src_w, rf_val
    );

    modport slave (
        input  req_valid, req_op, req_data, rf_a,
        output req_ready, done, addr, rf_src_a, rf_src_a_en, rf_we, rf_src_w, rf_val
    );

endinterface

// File: rtl/stack_seq.sv
// Stack-pointer sequencer: reads SP from regs E/F, computes the stack address and
// writes the updated SP back one half at a time, touching the high half only on carry.
module stack_seq
    import stack_seq_pkg::*;
(
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    stack_seq_if.slave  bus
);

    state_t              state, state_d;
    req_t                req_q, req_d;
    logic [HALF_W-1:0]   sp_lo_q, sp_lo_d;
    logic [HALF_W-1:0]   sp_hi_q, sp_hi_d;
    logic [SP_W-1:0]     sp_cur, sp_new;

    logic                ready_q, ready_d;
    logic                done_q, done_d;
    logic [SP_W-1:0]     addr_q, addr_d;
    logic [REG_W-1:0]    src_a_q, src_a_d;
    logic                src_a_en_q, src_a_en_d;
    logic                we_q, we_d;
    logic [REG_W-1:0]    src_w_q, src_w_d;
    logic [HALF_W-1:0]   val_q, val_d;

    // During RD_HI the high half is still on the bus, not yet in sp_hi_q
    always_comb begin
        sp_cur = {(state == RD_HI) ? bus.rf_a : sp_hi_q, sp_lo_q};
        sp_new = sp_step(req_q.op, sp_cur);
    end

    // Next state, captures, and next values of the registered outputs
    always_comb begin
        state_d    = state;
        req_d      = req_q;
        sp_lo_d    = sp_lo_q;
        sp_hi_d    = sp_hi_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        addr_d     = '0;
        src_a_d    = REG_NONE;
        src_a_en_d = 1'b0;
        we_d       = 1'b0;
        src_w_d    = REG_NONE;
        val_d      = '0;

        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.op   = bus.req_op;
                    req_d.data = bus.req_data;
                    state_d    = (bus.req_op == LOAD) ? WR_LO : RD_LO;
                end
            end
            RD_LO: begin
                sp_lo_d = bus.rf_a;
                state_d = RD_HI;
            end
            RD_HI: begin
                sp_hi_d = bus.rf_a;
                state_d = (req_q.op == PEEK) ? DONE : WR_LO;
            end
            WR_LO: begin
                state_d = (req_q.op == LOAD || carry_out(req_q.op, sp_lo_q)) ? WR_HI : DONE;
            end
            WR_HI:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE: ready_d = 1'b1;
            RD_LO: begin
                src_a_d    = REG_SP_LO;
                src_a_en_d = 1'b1;
            end
            RD_HI: begin
                src_a_d    = REG_SP_HI;
                src_a_en_d = 1'b1;
            end
            WR_LO: begin
                we_d    = 1'b1;
                src_w_d = REG_SP_LO;
                val_d   = (req_d.op == LOAD) ? req_d.data[HALF_W-1:0] : sp_new[HALF_W-1:0];
            end
            WR_HI: begin
                we_d    = 1'b1;
                src_w_d = REG_SP_HI;
                val_d   = (req_q.op == LOAD) ? req_q.data[SP_W-1:HALF_W] : sp_new[SP_W-1:HALF_W];
            end
            DONE: begin
                done_d = 1'b1;
                case (req_q.op)
                    PUSH:    addr_d = sp_new;
                    LOAD:    addr_d = req_q.data;
                    default: addr_d = sp_cur;
                endcase
            end
            default: ready_d = 1'b0;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            sp_lo_q    <= '0;
            sp_hi_q    <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            addr_q     <= '0;
            src_a_q    <= REG_NONE;
            src_a_en_q <= 1'b0;
            we_q       <= 1'b0;
            src_w_q    <= REG_NONE;
            val_q      <= '0;
        end else begin
            state      <= state_d;
            req_q      <= req_d;
            sp_lo_q    <= sp_lo_d;
            sp_hi_q    <= sp_hi_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            src_a_q    <= src_a_d;
            src_a_en_q <= src_a_en_d;
            we_q       <= we_d;
            src_w_q    <= src_w_d;
            val_q      <= val_d;
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.done        = done_q;
    assign bus.addr        = addr_q;
    assign bus.rf_src_a    = src_a_q;
    assign bus.rf_src_a_en = src_a_en_q;
    assign bus.rf_we       = we_q;
    assign bus.rf_src_w    = src_w_q;
    assign bus.rf_val      = val_q;

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq: a small register-file model, an operation
// vector table with a scoreboard, and hand-written reset/hold/back-to-back sequences.
module tb_stack_seq;
    import stack_seq_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int          lat;
    } res_t;

    typedef struct {
        op_t         op;
        logic [31:0] data;
        logic [31:0] exp_addr;
        int          exp_lat;
        logic [31:0] exp_sp;
        int          exp_wr;
    } vec_t;

    logic cpu_clk = 1'b0;
    logic cpu_rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_n = 0;
    int   bad_idle = 0;

    res_t        sb_q[$];
    res_t        obs_q[$];
    int          acc_q[$];
    int          acc_hist[$];
    logic [3:0]  rd_log[$];
    logic [19:0] wr_log[$];
    logic [15:0] regs [16];
    vec_t        vecs [12];

    stack_seq_if bus ();

    stack_seq dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst_n (cpu_rst_n),
        .bus       (bus)
    );

    initial forever #5 cpu_clk = ~cpu_clk;
    initial forever begin
        @(posedge cpu_clk);
        cyc++;
    end

    // Register file model: combinational read-A, write on the rising edge
    always @(posedge cpu_clk) begin
        if (bus.rf_we && bus.rf_src_w != REG_NONE) regs[bus.rf_src_w] <= bus.rf_val;
    end
    assign bus.rf_a = bus.rf_src_a_en ? regs[bus.rf_src_a] : 16'h0000;

    // Monitor: samples on the falling edge, logs bus activity and completed ops
    initial begin
        int a;
        forever begin
            @(negedge cpu_clk);
            if (cpu_rst_n) begin
                if (bus.req_valid && bus.req_ready) begin
                    acc_q.push_back(cyc + 1);
                    acc_hist.push_back(cyc + 1);
                    acc_n++;
                end
                if (bus.rf_src_a_en) rd_log.push_back(bus.rf_src_a);
                if (bus.rf_we) wr_log.push_back({bus.rf_src_w, bus.rf_val});
                if (!bus.rf_we && (bus.rf_src_w != 4'h0 || bus.rf_val != 16'h0)) bad_idle++;
                if (!bus.rf_src_a_en && bus.rf_src_a != 4'h0) bad_idle++;
                if (!bus.done && bus.addr != 32'h0) bad_idle++;
                if (bus.done) begin
                    a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                    obs_q.push_back('{addr: bus.addr, lat: cyc + 1 - a});
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    32'(bus.req_ready),   32'd1);
        check({tag, "_done"},     32'(bus.done),        32'd0);
        check({tag, "_addr"},     bus.addr,             32'd0);
        check({tag, "_src_a"},    32'(bus.rf_src_a),    32'd0);
        check({tag, "_src_a_en"}, 32'(bus.rf_src_a_en), 32'd0);
        check({tag, "_we"},       32'(bus.rf_we),       32'd0);
        check({tag, "_src_w"},    32'(bus.rf_src_w),    32'd0);
        check({tag, "_val"},      32'(bus.rf_val),      32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        @(posedge cpu_clk); #1;
        while (!bus.req_ready && n < 20) begin
            @(posedge cpu_clk); #1;
            n++;
        end
        check("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic issue(input op_t op, input logic [31:0] data, input logic [31:0] exp_addr, input int exp_lat);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = data;
        sb_q.push_back('{addr: exp_addr, lat: exp_lat});
        @(posedge cpu_clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Wait for every expected result, then pop and compare in order
    task automatic drain(input string name);
        res_t e, o;
        for (int n = 0; n < 60; n++) begin
            if (obs_q.size() >= sb_q.size()) break;
            @(posedge cpu_clk); #1;
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (obs_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: no done seen, expected addr 0x%08h", name, e.addr);
            end else begin
                o = obs_q.pop_front();
                check({name, "_addr"}, o.addr, e.addr);
                check({name, "_lat"},  32'(o.lat), 32'(e.lat));
            end
        end
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        acc_hist.delete();
    endtask

    initial begin
        logic [19:0] exp_w;
        int n0;

        vecs[0]  = '{LOAD, 32'h0001_0000, 32'h0001_0000, 3, 32'h0001_0000, 2};
        vecs[1]  = '{PUSH, 32'h0,         32'h0000_FFFF, 5, 32'h0000_FFFF, 2};
        vecs[2]  = '{LOAD, 32'h1234_5678, 32'h1234_5678, 3, 32'h1234_5678, 2};
        vecs[3]  = '{POP,  32'h0,         32'h1234_5678, 4, 32'h1234_5679, 1};
        vecs[4]  = '{LOAD, 32'h0000_0000, 32'h0000_0000, 3, 32'h0000_0000, 2};
        vecs[5]  = '{PUSH, 32'h0,         32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 2};
        vecs[6]  = '{POP,  32'h0,         32'hFFFF_FFFF, 5, 32'h0000_0000, 2};
        vecs[7]  = '{LOAD, 32'h8000_FFFF, 32'h8000_FFFF, 3, 32'h8000_FFFF, 2};
        vecs[8]  = '{POP,  32'h0,         32'h8000_FFFF, 5, 32'h8001_0000, 2};
        vecs[9]  = '{PEEK, 32'h0,         32'h8001_0000, 3, 32'h8001_0000, 0};
        vecs[10] = '{POP,  32'h0,         32'h8001_0000, 4, 32'h8001_0001, 1};
        vecs[11] = '{PUSH, 32'h0,         32'h8001_0000, 4, 32'h8001_0000, 1};

        cpu_rst_n     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = PUSH;
        bus.req_data  = 32'h0;
        repeat (3) @(posedge cpu_clk);
        #1;
        check_reset_outputs("rst");
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk); #1;
        check("post_rst_ready", 32'(bus.req_ready), 32'd1);

        // Table-driven operations
        for (int i = 0; i < 12; i++) begin
            clear_logs();
            issue(vecs[i].op, vecs[i].data, vecs[i].exp_addr, vecs[i].exp_lat);
            drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_rd_cnt", i), 32'(rd_log.size()), (vecs[i].op == LOAD) ? 32'd0 : 32'd2);
            if (rd_log.size() == 2) begin
                check($sformatf("vec%0d_rd0", i), 32'(rd_log[0]), 32'(REG_SP_LO));
                check($sformatf("vec%0d_rd1", i), 32'(rd_log[1]), 32'(REG_SP_HI));
            end
            check($sformatf("vec%0d_wr_cnt", i), 32'(wr_log.size()), 32'(vecs[i].exp_wr));
            for (int k = 0; k < wr_log.size() && k < 2; k++) begin
                exp_w = (k == 0) ? {REG_SP_LO, vecs[i].exp_sp[15:0]} : {REG_SP_HI, vecs[i].exp_sp[31:16]};
                check($sformatf("vec%0d_wr%0d", i, k), 32'(wr_log[k]), 32'(exp_w));
            end
            check($sformatf("vec%0d_sp", i), {regs[15], regs[14]}, vecs[i].exp_sp);
        end

        // PEEK with req_valid held through the busy cycles
        issue(LOAD, 32'hABCD_0042, 32'hABCD_0042, 3);
        drain("peek_load");
        clear_logs();
        wait_ready();
        n0 = acc_n;
        bus.req_valid = 1'b1;
        bus.req_op    = PEEK;
        sb_q.push_back('{addr: 32'hABCD_0042, lat: 3});
        sb_q.push_back('{addr: 32'hABCD_0042, lat: 3});
        for (int n = 0; n < 30; n++) begin
            @(posedge cpu_clk); #1;
            if (acc_n >= n0 + 2) break;
        end
        bus.req_valid = 1'b0;
        drain("peek_hold");
        check("peek_accepts", 32'(acc_hist.size()), 32'd2);
        if (acc_hist.size() >= 2)
            check("peek_reaccept_gap", 32'(acc_hist[1] - acc_hist[0]), 32'd4);
        check("peek_no_writes", 32'(wr_log.size()), 32'd0);

        // Back-to-back PUSH x3 with req_valid held
        issue(LOAD, 32'h0000_0010, 32'h0000_0010, 3);
        drain("b2b_load");
        wait_ready();
        n0 = acc_n;
        bus.req_valid = 1'b1;
        bus.req_op    = PUSH;
        sb_q.push_back('{addr: 32'h0000_000F, lat: 4});
        sb_q.push_back('{addr: 32'h0000_000E, lat: 4});
        sb_q.push_back('{addr: 32'h0000_000D, lat: 4});
        for (int n = 0; n < 60; n++) begin
            @(posedge cpu_clk); #1;
            if (acc_n >= n0 + 3) break;
        end
        bus.req_valid = 1'b0;
        drain("b2b_push");
        check("b2b_sp", {regs[15], regs[14]}, 32'h0000_000D);

        // Reset asserted during WR_LO of a PUSH aborts at once
        issue(LOAD, 32'h0000_0005, 32'h0000_0005, 3);
        drain("rst_load");
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_op    = PUSH;
        @(posedge cpu_clk); #1;
        bus.req_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge cpu_clk);
            if (bus.rf_we) break;
        end
        check("mid_push_in_wr_lo", 32'(bus.rf_we), 32'd1);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        acc_q.delete();
        obs_q.delete();
        sb_q.delete();
        @(posedge cpu_clk); #1;
        cpu_rst_n = 1'b1;
        @(posedge cpu_clk); #1;
        check("rst_release_ready", 32'(bus.req_ready), 32'd1);
        issue(PEEK, 32'h0, 32'h0000_0005, 3);
        drain("rst_peek");

        check("idle_bus_values", 32'(bad_idle), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
# stack_seq

Multi-cycle stack-pointer sequencer that owns the register file's SP pair (`sp_low` = reg 4'hE, `sp_high` = reg 4'hF) during push, pop, load and peek operations. It sits between the control unit and the register file's read-A and write ports. It reads the 32-bit SP, computes the memory address for the stack access, and writes the updated SP back one 16-bit half at a time. Carry/borrow propagates into `sp_high` only when needed.

## Interface
Parameters: none.

Ports:
- `cpu_clk` in 1: system clock; all state on rising edge.
- `cpu_rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: operation request.
- `req_op` in 2: 00 PUSH, 01 POP, 10 LOAD, 11 PEEK.
- `req_data` in 32: new SP value; used by LOAD only.
- `req_ready` out 1: high only in IDLE.
- `done` out 1: one-cycle pulse when the operation completes.
- `addr` out 32: stack address for the memory access; valid while `done`=1.
- `rf_src_a` out 4: register file read-A select.
- `rf_src_a_en` out 1: register file read-A output enable.
- `rf_a` in 16: register file A bus; combinational read.
- `rf_we` out 1: register file write enable.
- `rf_src_w` out 4: register file write select; 4'h0 means no write.
- `rf_val` out 16: register file write data.

## Operation
- Handshake: a request is accepted on a rising edge with `req_valid && req_ready`. `req_op` and `req_data` are captured at acceptance and held internally.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- PUSH (pre-decrement): new SP = SP − 1; `addr` = new SP. Path: RD_LO → RD_HI → WR_LO → (WR_HI only if `sp_low` was 16'h0000) → DONE.
- POP (post-increment): `addr` = old SP; new SP = SP + 1. Path: RD_LO → RD_HI → WR_LO → (WR_HI only if `sp_low` was 16'hFFFF) → DONE.
- LOAD: writes `req_data[15:0]` to reg E, then `req_data[31:16]` to reg F. Path: WR_LO → WR_HI → DONE. `addr` = `req_data`.
- PEEK: RD_LO → RD_HI → DONE. `addr` = SP; no writes.
- RD_LO: `rf_src_a`=4'hE, `rf_src_a_en`=1; `rf_a` is captured into `sp_lo_q` at the end of the cycle. RD_HI is the same with 4'hF into `sp_hi_q`.
- WR_LO: `rf_we`=1, `rf_src_w`=4'hE, `rf_val`=new low half. WR_HI is the same with 4'hF and the new high half.
- Arithmetic: full 32-bit modulo 2^32.
  - PUSH at 0000_0000 → FFFF_FFFF; both halves are written.
  - POP at FFFF_FFFF → 0000_0000; both halves are written.
- Outside read states: `rf_src_a`=4'h0 and `rf_src_a_en`=0, so the bus is high-Z.
- Outside write states: `rf_we`=0, `rf_src_w`=4'h0, `rf_val`=16'h0000.
- DONE always returns to IDLE the next cycle. `req_valid` is ignored outside IDLE; there is no queueing.

## Timing
- Reset (asynchronous assert, synchronous deassert by the clock tree):
  - State → IDLE.
  - `req_ready`=1, `done`=0, `addr`=0.
  - `rf_src_a`=0, `rf_src_a_en`=0, `rf_we`=0, `rf_src_w`=0, `rf_val`=0.
  - `sp_lo_q`/`sp_hi_q`=0.
- Reset mid-operation aborts immediately. A half-written SP is left as-is and is not repaired.
- Latency counts cycles from the acceptance edge to the edge ending `done`:
  - PUSH/POP with no carry: 4 cycles (RD_LO, RD_HI, WR_LO, DONE).
  - PUSH/POP with carry: 5 cycles.
  - LOAD: 3 cycles.
  - PEEK: 3 cycles.
- Each register file write commits on the rising edge that ends its WR state.
- `addr` is registered and driven only in DONE; it is 0 otherwise.
- `req_ready` is low from the cycle after acceptance through DONE. A new request can be accepted on the edge ending the IDLE cycle that follows DONE.
- Back-to-back: ops are serialised. The second op's RD_LO sees the first op's written SP, because the write committed at least 2 cycles earlier.

## Structure
- Package `stack_seq_pkg` holds:
  - `op_t` enum: PUSH, POP, LOAD, PEEK.
  - `state_t` enum: the six states above.
  - Constants `REG_NONE`=4'h0, `REG_SP_LO`=4'hE, `REG_SP_HI`=4'hF.
- The package is shared with the control unit decoder.
- Single module, with no sub-module. The 32-bit ±1 adder and carry detect are inline.
- Estimated size is about 200 lines.

## Test plan
- Reset mid-PUSH (assert during WR_LO) → all outputs return to their reset values asynchronously. After release, `req_ready`=1.
- LOAD 0x0001_0000, then PUSH:
  - Reads are E then F.
  - E←0xFFFF, then F←0x0000 (the WR_HI path is taken).
  - `done` with `addr`=0x0000_FFFF, 5 cycles after acceptance.
- LOAD 0x1234_5678, then POP:
  - `addr`=0x1234_5678.
  - Only E is written, with 0x5679; `rf_src_w` never equals 4'hF.
  - 4-cycle latency.
- Wrap-around, both directions:
  - LOAD 0x0000_0000 then PUSH → `addr`=0xFFFF_FFFF.
  - Then POP → `addr`=0xFFFF_FFFF and SP=0x0000_0000.
  - Both halves are written in each op.
- PEEK after LOAD 0xABCD_0042:
  - `addr`=0xABCD_0042 with 3-cycle latency.
  - `rf_we`=0 throughout.
  - `req_valid` held high during busy cycles is not accepted until IDLE.
- Back-to-back PUSH×3 from 0x0000_0010 with `req_valid` held high → `addr` sequence 0x0F, 0x0E, 0x0D; final SP=0x0000_000D.
